// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback path: widths and the
// {rd, data} result record carried through the load FIFO.
package wb_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_result_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus bundle: ALU/load result offers, decode issue, register-file
// write port and scoreboard. Forwarding signals exist only with WB_FWD_EN.
interface regfile_wb_arbiter_if;
  import wb_pkg::*;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [XLEN-1:0]       mem_data;
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] rd;
  logic [XLEN-1:0]       write_data;
  logic [NUM_REGS-1:0]   pending;
`ifdef WB_FWD_EN
  logic [REG_ADDR_W-1:0] fwd_rs1;
  logic [REG_ADDR_W-1:0] fwd_rs2;
  logic                  fwd1_hit;
  logic                  fwd2_hit;
  logic [XLEN-1:0]       fwd1_data;
  logic [XLEN-1:0]       fwd2_data;
`endif

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output issue_valid, issue_rd,
`ifdef WB_FWD_EN
    output fwd_rs1, fwd_rs2,
    input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
`endif
    input  alu_ready, mem_ready, reg_write, rd, write_data, pending
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  issue_valid, issue_rd,
`ifdef WB_FWD_EN
    input  fwd_rs1, fwd_rs2,
    output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
`endif
    output alu_ready, mem_ready, reg_write, rd, write_data, pending
  );
endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_result_t records; power-of-two depth, pointers wrap
// naturally and the occupancy count carries one extra bit to tell full from empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  wb_result_t din,
  input  logic       pop,
  output wb_result_t dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  wb_result_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     cnt;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: load FIFO, ALU anti-starvation priority,
// registered write port and pending-write scoreboard. Optional WB_FWD_EN adds bypass.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int MEM_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_wb_arbiter_if.slave   bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  wb_result_t            fifo_head;
  wb_result_t            fifo_din;
  wb_result_t            win;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop_sel;
  logic                  alu_ready;
  logic                  alu_grant;
  logic                  grant;
  logic [SW-1:0]         starve_cnt;
  logic                  reg_write_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       write_data_q;
  logic [NUM_REGS-1:0]   pending_q;
  logic [NUM_REGS-1:0]   pending_nxt;

  assign fifo_din = '{rd: bus.mem_rd, data: bus.mem_data};

  wb_fifo #(.DEPTH(MEM_FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.mem_valid && bus.mem_ready),
    .din   (fifo_din),
    .pop   (pop_sel),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Loads win unless the ALU has waited STARVE_LIMIT cycles.
  assign pop_sel   = !reset && !fifo_empty && (starve_cnt < STARVE_MAX);
  assign alu_ready = !reset && !pop_sel;
  assign alu_grant = bus.alu_valid && alu_ready;
  assign grant     = pop_sel || alu_grant;
  assign win       = pop_sel ? fifo_head : '{rd: bus.alu_rd, data: bus.alu_data};

  assign bus.alu_ready  = alu_ready;
  assign bus.mem_ready  = !reset && !fifo_full;
  assign bus.reg_write  = reg_write_q;
  assign bus.rd         = rd_q;
  assign bus.write_data = write_data_q;
  assign bus.pending    = pending_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (bus.alu_valid && !alu_ready) begin
      if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // x0 results are consumed without touching the write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      write_data_q <= '0;
    end else begin
      reg_write_q <= grant && (win.rd != '0);
      if (grant && (win.rd != '0)) begin
        rd_q         <= win.rd;
        write_data_q <= win.data;
      end
    end
  end

  // A fresh issue overrides a same-cycle retire: a newer producer exists.
  always_comb begin
    pending_nxt = pending_q;
    if (reg_write_q) pending_nxt[rd_q] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != '0)) pending_nxt[bus.issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_nxt;
  end

`ifdef WB_FWD_EN
  assign bus.fwd1_hit  = reg_write_q && (rd_q == bus.fwd_rs1) && (bus.fwd_rs1 != '0);
  assign bus.fwd2_hit  = reg_write_q && (rd_q == bus.fwd_rs2) && (bus.fwd_rs2 != '0);
  assign bus.fwd1_data = write_data_q;
  assign bus.fwd2_data = write_data_q;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table-driven bench for regfile_wb_arbiter plus hand sequences for
// reset mid-stream and (when WB_FWD_EN is defined) forwarding.
module tb_regfile_wb_arbiter;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.MEM_FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        iv;
    logic [4:0]  ir;
    logic        ar;
    logic        mr;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [31:0] pend;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] ad,
                              logic mv, logic [4:0] mrd, logic [31:0] md,
                              logic iv, logic [4:0] ir,
                              logic ar, logic mr, logic rw, logic [4:0] rd,
                              logic [31:0] wd, logic [31:0] pend);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.mv = mv; v.mrd = mrd; v.md = md;
    v.iv = iv; v.ir = ir;
    v.ar = ar; v.mr = mr; v.rw = rw; v.rd = rd; v.wd = wd; v.pend = pend;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 0; bus.mem_rd = '0; bus.mem_data = '0;
    bus.issue_valid = 0; bus.issue_rd = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //             av ard  ad            mv mrd md       iv ir  ar mr rw rd  wd            pending
    vecs[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  0,       0, 0,  1, 1, 1, 5,  32'hDEADBEEF, 32'h0);
    vecs[1]  = mk(0, 0,  0,            0, 0,  0,       1, 7,  1, 1, 0, 5,  32'hDEADBEEF, 32'h80);
    vecs[2]  = mk(1, 0,  32'h1234,     0, 0,  0,       1, 0,  1, 1, 0, 5,  32'hDEADBEEF, 32'h80);
    vecs[3]  = mk(0, 0,  0,            1, 7,  32'h77,  0, 0,  1, 1, 0, 5,  32'hDEADBEEF, 32'h80);
    vecs[4]  = mk(0, 0,  0,            0, 0,  0,       0, 0,  0, 1, 1, 7,  32'h77,       32'h80);
    vecs[5]  = mk(0, 0,  0,            0, 0,  0,       1, 7,  1, 1, 0, 7,  32'h77,       32'h80);
    vecs[6]  = mk(0, 0,  0,            1, 7,  32'h88,  0, 0,  1, 1, 0, 7,  32'h77,       32'h80);
    vecs[7]  = mk(0, 0,  0,            0, 0,  0,       0, 0,  0, 1, 1, 7,  32'h88,       32'h80);
    vecs[8]  = mk(0, 0,  0,            0, 0,  0,       0, 0,  1, 1, 0, 7,  32'h88,       32'h0);
    // continuous loads with the ALU held: ALU wins one slot in four, FIFO creeps to full
    vecs[9]  = mk(0, 0,  0,            1, 1,  32'h101, 0, 0,  1, 1, 0, 7,  32'h88,       32'h0);
    vecs[10] = mk(1, 20, 32'hA0000020, 1, 2,  32'h102, 0, 0,  0, 1, 1, 1,  32'h101,      32'h0);
    vecs[11] = mk(1, 20, 32'hA0000020, 1, 3,  32'h103, 0, 0,  0, 1, 1, 2,  32'h102,      32'h0);
    vecs[12] = mk(1, 20, 32'hA0000020, 1, 4,  32'h104, 0, 0,  0, 1, 1, 3,  32'h103,      32'h0);
    vecs[13] = mk(1, 20, 32'hA0000020, 1, 5,  32'h105, 0, 0,  1, 1, 1, 20, 32'hA0000020, 32'h0);
    vecs[14] = mk(1, 21, 32'hA0000021, 1, 6,  32'h106, 0, 0,  0, 1, 1, 4,  32'h104,      32'h0);
    vecs[15] = mk(1, 21, 32'hA0000021, 1, 7,  32'h107, 0, 0,  0, 1, 1, 5,  32'h105,      32'h0);
    vecs[16] = mk(1, 21, 32'hA0000021, 1, 8,  32'h108, 0, 0,  0, 1, 1, 6,  32'h106,      32'h0);
    vecs[17] = mk(1, 21, 32'hA0000021, 1, 9,  32'h109, 0, 0,  1, 1, 1, 21, 32'hA0000021, 32'h0);
    vecs[18] = mk(1, 22, 32'hA0000022, 1, 10, 32'h10A, 0, 0,  0, 1, 1, 7,  32'h107,      32'h0);
    vecs[19] = mk(1, 22, 32'hA0000022, 1, 11, 32'h10B, 0, 0,  0, 1, 1, 8,  32'h108,      32'h0);
    vecs[20] = mk(1, 22, 32'hA0000022, 1, 12, 32'h10C, 0, 0,  0, 1, 1, 9,  32'h109,      32'h0);
    vecs[21] = mk(1, 22, 32'hA0000022, 1, 13, 32'h10D, 0, 0,  1, 1, 1, 22, 32'hA0000022, 32'h0);
    vecs[22] = mk(1, 23, 32'hA0000023, 1, 14, 32'h10E, 1, 3,  0, 0, 1, 10, 32'h10A,      32'h8);

    drive_idle();
`ifdef WB_FWD_EN
    bus.fwd_rs1 = '0;
    bus.fwd_rs2 = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_reg_write", 32'(bus.reg_write), 32'h0);
    check("rst_rd", 32'(bus.rd), 32'h0);
    check("rst_wdata", bus.write_data, 32'h0);
    check("rst_pending", bus.pending, 32'h0);
    check("rst_alu_ready", 32'(bus.alu_ready), 32'h0);
    check("rst_mem_ready", 32'(bus.mem_ready), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rel_mem_ready", 32'(bus.mem_ready), 32'h1);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.alu_valid = vecs[i].av; bus.alu_rd = vecs[i].ard; bus.alu_data = vecs[i].ad;
      bus.mem_valid = vecs[i].mv; bus.mem_rd = vecs[i].mrd; bus.mem_data = vecs[i].md;
      bus.issue_valid = vecs[i].iv; bus.issue_rd = vecs[i].ir;
      #1;
      check($sformatf("v%0d_alu_ready", i), 32'(bus.alu_ready), 32'(vecs[i].ar));
      check($sformatf("v%0d_mem_ready", i), 32'(bus.mem_ready), 32'(vecs[i].mr));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_reg_write", i), 32'(bus.reg_write), 32'(vecs[i].rw));
      check($sformatf("v%0d_rd", i), 32'(bus.rd), 32'(vecs[i].rd));
      check($sformatf("v%0d_wdata", i), bus.write_data, vecs[i].wd);
      check($sformatf("v%0d_pending", i), bus.pending, vecs[i].pend);
    end

    // Reset mid-stream with three loads still queued and a write in progress.
    #2;
    drive_idle();
    reset = 1'b1;
    #1;
    check("mid_rst_reg_write", 32'(bus.reg_write), 32'h0);
    check("mid_rst_pending", bus.pending, 32'h0);
    check("mid_rst_mem_ready", 32'(bus.mem_ready), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rel_mem_ready", 32'(bus.mem_ready), 32'h1);
    check("mid_rel_alu_ready", 32'(bus.alu_ready), 32'h1);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("flushed_c%0d_reg_write", c), 32'(bus.reg_write), 32'h0);
      check($sformatf("flushed_c%0d_pending", c), bus.pending, 32'h0);
    end

`ifdef WB_FWD_EN
    @(negedge clk);
    bus.alu_valid = 1; bus.alu_rd = 5'd9; bus.alu_data = 32'hA5A5A5A5;
    @(negedge clk);
    drive_idle();
    bus.fwd_rs1 = 5'd9;
    bus.fwd_rs2 = 5'd0;
    #1;
    check("fwd1_hit", 32'(bus.fwd1_hit), 32'h1);
    check("fwd1_data", bus.fwd1_data, 32'hA5A5A5A5);
    check("fwd2_hit_x0", 32'(bus.fwd2_hit), 32'h0);
    bus.fwd_rs1 = 5'd0;
    bus.fwd_rs2 = 5'd9;
    #1;
    check("fwd1_hit_x0", 32'(bus.fwd1_hit), 32'h0);
    check("fwd2_hit", 32'(bus.fwd2_hit), 32'h1);
    @(posedge clk);
    #1;
    check("fwd2_hit_no_write", 32'(bus.fwd2_hit), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
